// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one result bit per clock,
// LSB first. D = A - B - Bin (mod 2^WIDTH), Bout = final borrow.
// Optional build macro SERIAL_SUB_OVERFLOW_EN adds output V (signed overflow).
//
// state | meaning
// IDLE  | ready=1, waiting for start; operands captured on accept
// SHIFT | producing one difference bit per cycle, WIDTH cycles
// DONE  | full difference in shift register; copied to D/Bout, done follows
//
// done and the D/Bout/V outputs are registered on the DONE->IDLE edge, so the
// done pulse lands in the first IDLE cycle and back-to-back operations still
// run at one per WIDTH+2 cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             done
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             diff_bit;
  logic             borrow_nxt;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
`endif

  assign ready    = (state == IDLE);
  assign accept   = ready && start;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs of the operand shift registers
  always_comb begin
    diff_bit   = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and serial datapath; partial result stays internal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      d_sh   <= '0;
      borrow <= Bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      d_sh   <= {diff_bit, d_sh[WIDTH-1:1]};
      borrow <= borrow_nxt;
      cnt    <= cnt + CW'(1);
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits kept for the overflow flag, since the shifters consume them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
    end
  end
`endif

  // Result registers and done pulse; D/Bout hold until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D    <= '0;
      Bout <= 1'b0;
      done <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      V    <= 1'b0;
`endif
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        D    <= d_sh;
        Bout <= borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
        V    <= (a_msb ^ b_msb) & (a_msb ^ d_sh[WIDTH-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8). Checks V only when built
// with SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         v;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] last_d;
  logic         last_b;

  logic [W-1:0] burst_a  [3];
  logic [W-1:0] burst_b  [3];
  logic         burst_bi [3];
  logic [W-1:0] burst_d  [3];
  logic         burst_bo [3];
  logic         burst_v  [3];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .ready (ready),
    .D     (D),
    .Bout  (Bout),
    .done  (done)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .V     (v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check(tag, v, exp);
`endif
  endtask

  // Called at a negedge while idle. Applies one operation, checks busy cycles
  // (start ignored, operands scrambled, D holding old value), then the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic ev);
    check("idle_ready", ready, 1'b1);
    A = a;
    B = b;
    Bin = bi;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_ready0", ready, 1'b0);
    for (int k = 1; k <= W + 1; k++) begin
      A = W'($urandom);
      B = W'($urandom);
      Bin = 1'($urandom);
      start = k[0];
      @(negedge clk);
      if (k <= W) begin
        check("busy_done0", done, 1'b0);
        check("busy_ready", ready, 1'b0);
        check("busy_d_hold", D, last_d);
      end else begin
        start = 1'b0;
        check("op_done", done, 1'b1);
        check("op_ready", ready, 1'b1);
        check("op_d", D, ed);
        check("op_bout", Bout, eb);
        check_v("op_v", ev);
      end
    end
    last_d = ed;
    last_b = eb;
    @(negedge clk);
    check("done_pulse_end", done, 1'b0);
    check("d_after", D, last_d);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    Bin = 1'b0;
    last_d = '0;
    last_b = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_d", D, 8'h00);
    check("rst_bout", Bout, 1'b0);
    check_v("rst_v", 1'b0);
    rst_n = 1'b1;

    // start in the same cycle reset releases: accepted on the very next edge
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0);

    // start held high: accepts at c=0,10,20 with operands changing every cycle
    burst_a[0] = 8'h50; burst_b[0] = 8'h20; burst_bi[0] = 1'b0;
    burst_d[0] = 8'h30; burst_bo[0] = 1'b0; burst_v[0] = 1'b0;
    burst_a[1] = 8'h20; burst_b[1] = 8'h50; burst_bi[1] = 1'b1;
    burst_d[1] = 8'hCF; burst_bo[1] = 1'b1; burst_v[1] = 1'b0;
    burst_a[2] = 8'h7F; burst_b[2] = 8'h80; burst_bi[2] = 1'b0;
    burst_d[2] = 8'hFF; burst_bo[2] = 1'b1; burst_v[2] = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      check("burst_ready", ready, (c % 10) == 0);
      if (c > 0) begin
        check("burst_done", done, (c % 10) == 0);
        if ((c % 10) == 0) begin
          check("burst_d", D, burst_d[c / 10 - 1]);
          check("burst_bout", Bout, burst_bo[c / 10 - 1]);
          check_v("burst_v", burst_v[c / 10 - 1]);
          last_d = burst_d[c / 10 - 1];
          last_b = burst_bo[c / 10 - 1];
        end else begin
          check("burst_d_hold", D, last_d);
        end
      end
      if (c == 30) begin
        start = 1'b0;
      end else begin
        start = 1'b1;
      end
      if ((c % 10) == 0 && c < 30) begin
        A = burst_a[c / 10];
        B = burst_b[c / 10];
        Bin = burst_bi[c / 10];
      end else begin
        A = W'($urandom);
        B = W'($urandom);
        Bin = 1'($urandom);
      end
      @(negedge clk);
    end
    check("burst_end_done", done, 1'b0);
    check("burst_end_ready", ready, 1'b1);

    // reset mid-SHIFT aborts; outputs clear without a clock edge
    A = 8'h33;
    B = 8'h11;
    Bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_d", D, 8'h00);
    check("abort_bout", Bout, 1'b0);
    check("abort_done", done, 1'b0);
    check_v("abort_v", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_d = '0;
    last_b = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
